muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, placed beside the combinational ALU on the same operand buses (A = rs1 value, B = rs2 value).
- The ALU returns a result in the same cycle. This block accepts an operation with a start pulse and returns the result several cycles later with a done pulse.
- The control path stalls the PC while busy is high.
- Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- ITER, 32, number of iteration cycles; must equal XLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  input  32  operand rs1, signed view.
- B  input  32  operand rs2, signed view.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  32  result; holds its value until the next accepted start.

Behaviour:
- Reset values (rst high at a clock edge): state=IDLE, busy=0, done=0, result=0, all internal registers cleared. A reset mid-operation aborts the operation with no done pulse.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: on start, latch funct3, A and B; convert to magnitudes per signedness; record result sign; go to CALC; iteration count=0.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After ITER steps, go to FIX.
  - FIX: apply sign correction (two's complement negate if needed), select the low/high product word or quotient/remainder, register result. Go to DONE.
  - DONE: done=1 for exactly this cycle. On start, act as IDLE (accept, go to CALC; back-to-back allowed). Otherwise go to IDLE.
- Latency: start accepted at edge k → busy=1 from k+1, CALC spans 32 cycles, FIX 1 cycle, done=1 during cycle k+34. Total 34 cycles from start to done.
- busy=1 in CALC and FIX; 0 in IDLE and DONE.
- start while busy is ignored and does not queue.
- Inputs A, B and funct3 are don't-care after the accepting edge.
- Signedness:
  - MULH: signed × signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM: signed.
  - Product is 64 bits. MUL returns [31:0]; MULH* return [63:32].
- Divide semantics:
  - Quotient rounds toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (B=0):
  - DIV and DIVU quotient = 0xFFFFFFFF.
  - REM and REMU remainder = A.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- The divide-by-zero and overflow special cases still take the full 34 cycles unless the optional feature is enabled.
- No exceptions or flags are produced.

Optional Feature:
- Macro: MULDIV_FASTPATH_EN.
- Defined: the IDLE/DONE accept logic detects B=0, the signed-overflow case, or A=0. It loads the final result directly and goes straight to DONE, so done is high in cycle k+1 and busy never rises.
- Not defined: every operation takes 34 cycles; the fast-path detection logic is absent.

Test Plan:
- Reset mid-CALC (rst at cycle 10 after start) → busy=0, done never pulses, result=0; a following MUL 3×4 still returns 12.
- MUL A=0xFFFFFFFF (−1), B=7 → done at start+34, result=0xFFFFFFF9. MULH same operands → 0xFFFFFFFF. MULHU same operands → 0x00000006.
- DIV A=−7 (0xFFFFFFF9), B=2 → result 0xFFFFFFFD (−3). REM same operands → 0xFFFFFFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV A=5, B=0 → 0xFFFFFFFF. REM A=5, B=0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0. Without MULDIV_FASTPATH_EN each takes 34 cycles; with it, done at start+1.
- Back-to-back: start held high through the DONE cycle with a new op → second op accepted, second done exactly 34 cycles after the first done. start pulses while busy → ignored, no extra done.
- MULHSU A=0xFFFFFFFF (−1), B=0xFFFFFFFF (2^32−1) → result 0xFFFFFFFF; result unchanged through the following idle cycles until the next start.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit. It sits beside the single-cycle ALU on
//   the same operand buses. An operation is accepted with a start pulse. The
//   result comes back with a one-cycle done pulse 34 cycles later. Every case
//   takes those 34 cycles unless the fast path is built in.
//
//   Optional feature (macro MULDIV_FASTPATH_EN): the accept logic catches
//   divide-by-zero, signed divide overflow and A == 0. It loads the final result
//   directly and goes straight to DONE. done rises one cycle after the start
//   and busy never rises.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active-high
//   start   request; sampled only in IDLE or DONE
//   funct3  RV32M op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   A, B    operands (rs1, rs2)
//   busy    high while an operation is in flight (CALC and FIX)
//   done    one-cycle pulse, result valid in that cycle
//   result  result word; holds until the next accepted operation completes
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [2:0]      op;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] hi, lo;      // product {hi,lo}, or divide {remainder,quotient}
    logic            neg;         // negate the selected result in FIX
    logic            div_zero;

    // ---------------- operand conditioning at accept ----------------
    logic            a_signed, b_signed, a_neg, b_neg, b_is_zero, neg_in, accept;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg     = a_signed & A[XLEN-1];
    assign b_neg     = b_signed & B[XLEN-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;
    assign b_is_zero = (B == '0);
    // Remainder follows the dividend. The quotient sign is xor of the operand
    // signs, and a zero divisor is overridden in FIX anyway.
    assign neg_in    = funct3[2] ? (funct3[1] ? a_neg : ((a_neg ^ b_neg) & ~b_is_zero))
                                 : (a_neg ^ b_neg);
    assign accept    = start && ((state == IDLE) || (state == DONE));

`ifdef MULDIV_FASTPATH_EN
    logic            fast_hit;
    logic [XLEN-1:0] fast_val;
    logic            div_ovf;

    assign div_ovf = funct3[2] && !funct3[0] &&
                     (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);

    always_comb begin
        fast_hit = 1'b1;
        fast_val = '0;
        if (funct3[2] && b_is_zero)  fast_val = funct3[1] ? A : '1;
        else if (div_ovf)            fast_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else if (A == '0)            fast_val = '0;
        else                         fast_hit = 1'b0;
    end
`endif

    // ---------------- one iteration step ----------------
    // Shift-add multiply: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole product right.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi, mul_lo;
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract when it fits. The borrow bit of the difference is the compare.
    logic [XLEN:0]   rem_sh, diff;
    logic            fits;
    logic [XLEN-1:0] div_hi, div_lo;
    assign rem_sh = {hi, lo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, mag_b};
    assign fits   = ~diff[XLEN];
    assign div_hi = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign div_lo = {lo[XLEN-2:0], fits};

    // ---------------- sign fix and word select ----------------
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   div_sel, div_s, fix_val;
    assign prod_s  = neg ? -{hi, lo} : {hi, lo};
    assign div_sel = op[1] ? hi : lo;
    assign div_s   = neg ? -div_sel : div_sel;

    always_comb begin
        if (op[2])              fix_val = (div_zero && !op[1]) ? '1 : div_s;
        else if (op == 3'b000)  fix_val = prod_s[XLEN-1:0];
        else                    fix_val = prod_s[2*XLEN-1:XLEN];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
`ifdef MULDIV_FASTPATH_EN
                    state_next = fast_hit ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == CW'(ITER - 1)) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    // NOTE: state elements update with non-blocking assignments so that every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        // NOTE: every datapath register is cleared on reset, not only the
        // control state. An aborted operation then leaves nothing stale behind.
        if (rst) begin
            count    <= '0;
            op       <= '0;
            mag_b    <= '0;
            hi       <= '0;
            lo       <= '0;
            neg      <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op       <= funct3;
                        mag_b    <= b_mag;
                        hi       <= '0;
                        lo       <= a_mag;
                        neg      <= neg_in;
                        div_zero <= funct3[2] & b_is_zero;
                        count    <= '0;
`ifdef MULDIV_FASTPATH_EN
                        if (fast_hit) result <= fast_val;
`endif
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (op[2]) begin
                        hi <= div_hi;
                        lo <= div_lo;
                    end else begin
                        hi <= mul_hi;
                        lo <= mul_lo;
                    end
                end
                FIX:     result <= fix_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit. The stimulus process pushes the expected
//   result and latency of each operation. A separate monitor on the falling
//   edge pops an entry on every done pulse and compares it. A done pulse with
//   nothing expected is reported.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] result;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                           DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .A(A), .B(B), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          start_cyc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles from the cycle start is high to the cycle done is high.
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
        if (f[2] && b == 32'h0) return 1;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (a == 32'h0) return 1;
`endif
        return 34;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, result, e.res);
                check({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
                check({e.name, "_busy_at_done"}, {31'b0, busy}, 32'h0);
            end
        end
    end

    // Drive start for one cycle at the current falling edge and push the expectation.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        exp_t e;
        funct3 = f; A = a; B = b; start = 1'b1;
        e.res = exp; e.start_cyc = cyc; e.lat = exp_lat(f, a, b); e.name = name;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        @(negedge clk);
        launch(f, a, b, exp, name);
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; funct3 = 3'($urandom);   // don't-care after accept
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
        issue(f, a, b, exp, name);
        drain();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; funct3 = 3'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy",   {31'b0, busy}, 32'h0);
        check("reset_done",   {31'b0, done}, 32'h0);
        check("reset_result", result,        32'h0);

        // Multiply family
        run(MUL,    32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFF9, "mul_m1x7");
        run(MULH,   32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFFF, "mulh_m1x7");
        run(MULHU,  32'hFFFF_FFFF, 32'd7,         32'h0000_0006, "mulhu_m1x7");
        run(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");

        // Divide family
        run(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
        run(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
        run(DIVU,   32'd100,       32'd7,         32'd14,        "divu_100_7");
        run(REMU,   32'd100,       32'd7,         32'd2,         "remu_100_7");

        // Divide by zero and signed overflow
        run(DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, "div_5_0");
        run(REM,    32'd5,         32'd0,         32'd5,         "rem_5_0");
        run(DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_m5_0");
        run(REMU,   32'h1234_5678, 32'd0,         32'h1234_5678, "remu_x_0");
        run(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");

        // Reset in the middle of CALC: no done, busy low, result cleared
        issue(MUL, 32'd9, 32'd9, 32'd81, "mul_aborted");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   {31'b0, busy}, 32'h0);
        check("abort_result", result,        32'h0);
        repeat (40) @(negedge clk);
        check("abort_result_later", result, 32'h0);
        run(MUL, 32'd3, 32'd4, 32'd12, "mul_3x4_after_abort");

        // Back-to-back: start held through the DONE cycle, plus ignored starts while busy
        issue(MULHU, 32'hFFFF_FFFF, 32'd7, 32'h0000_0006, "b2b_first");
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        launch(DIVU, 32'd100, 32'd7, 32'd14, "b2b_second");
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        funct3 = MUL; A = 32'd2; B = 32'd2; start = 1'b1;     // must be ignored
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        funct3 = REM; A = 32'd9; B = 32'd4; start = 1'b1;     // must be ignored
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        check("b2b_result_kept", result, 32'd14);

        // MULHSU and result hold through idle cycles
        run(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_umax");
        for (int i = 0; i < 5; i++) begin
            check("mulhsu_hold", result, 32'hFFFF_FFFF);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
